// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencing controller for the E stage.
// An accepted mult/multu/div/divu computes its result into shadow registers,
// holds it for a fixed latency, then commits it to architectural HI/LO.
// mthi/mtlo write HI/LO directly when the unit is idle.
// Optional feature macro: MD_CANCEL_EN (adds the cancel port for E-stage flush).
module md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] shadow_hi_r;
  logic [31:0] shadow_lo_r;

  logic        cancel_s;
  logic        is_md_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic [31:0] abs_rs_s;
  logic [31:0] abs_rt_s;
  logic [31:0] dvd_s;
  logic [31:0] dvs_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

`ifdef MD_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  // A flush in the same cycle suppresses acceptance of the E-stage op.
  assign is_md_s = (e_op >= 3'd1) && (e_op <= 3'd4);
  assign start   = e_valid && is_md_s && (state_r == IDLE) && !cancel_s;
  assign stall_d = d_md_use && (start || busy);

  // Both products are formed at full 64-bit width from explicitly extended operands.
  assign smul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign umul_s = {32'd0, rs_val} * {32'd0, rt_val};

  // One unsigned divider serves both divides; signed div works on magnitudes
  // and fixes signs afterwards, which also keeps INT_MIN / -1 well defined.
  assign abs_rs_s = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign abs_rt_s = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign dvd_s    = (e_op == 3'd3) ? abs_rs_s : rs_val;
  assign dvs_s    = (rt_val == 32'd0) ? 32'd1 : ((e_op == 3'd3) ? abs_rt_s : rt_val);
  assign uq_s     = dvd_s / dvs_s;
  assign ur_s     = dvd_s % dvs_s;

  // Result selection; divide by zero reloads current HI/LO so commit is a no-op.
  always_comb begin
    res_hi_s = hi;
    res_lo_s = lo;
    case (e_op)
      3'd1: begin
        res_hi_s = smul_s[63:32];
        res_lo_s = smul_s[31:0];
      end
      3'd2: begin
        res_hi_s = umul_s[63:32];
        res_lo_s = umul_s[31:0];
      end
      3'd3: begin
        if (rt_val != 32'd0) begin
          res_lo_s = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq_s) : uq_s;
          res_hi_s = rs_val[31] ? (32'd0 - ur_s) : ur_s;
        end else begin
          res_hi_s = hi;
          res_lo_s = lo;
        end
      end
      3'd4: begin
        if (rt_val != 32'd0) begin
          res_lo_s = uq_s;
          res_hi_s = ur_s;
        end else begin
          res_hi_s = hi;
          res_lo_s = lo;
        end
      end
      default: begin
        res_hi_s = hi;
        res_lo_s = lo;
      end
    endcase
  end

  // Sequencing FSM: accept, count down the latency, commit shadow to HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      cnt_r       <= 4'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      shadow_hi_r <= 32'd0;
      shadow_lo_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            shadow_hi_r <= res_hi_s;
            shadow_lo_r <= res_lo_s;
            cnt_r       <= (e_op <= 3'd2) ? 4'(MULT_LAT) : 4'(DIV_LAT);
            busy        <= 1'b1;
            state_r     <= RUN;
          end else if (e_valid && !cancel_s && (e_op == 3'd5)) begin
            hi <= rs_val;
          end else if (e_valid && !cancel_s && (e_op == 3'd6)) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (cancel_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              hi      <= shadow_hi_r;
              lo      <= shadow_lo_r;
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: the driver pushes the expected HI/LO and busy
// length of every accepted op; a monitor pops and compares on each commit.
module tb_md_sched;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [2:0]  e_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        cancel;
  logic        start;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start), .busy(busy), .stall_d(stall_d), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  logic        abort_flag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic from the instruction definitions, using 64-bit integers.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb_, q, r;
    logic [63:0] p;
    nh = hi_m;
    nl = lo_m;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb_); nh = p[63:32]; nl = p[31:0]; end
      3'd2: begin p = 64'({32'd0, a}) * 64'({32'd0, b}); nh = p[63:32]; nl = p[31:0]; end
      3'd3: if (b != 32'd0) begin
              q = sa / sb_; r = sa % sb_;
              p = 64'(q); nl = p[31:0];
              p = 64'(r); nh = p[31:0];
            end
      3'd4: if (b != 32'd0) begin nl = a / b; nh = a % b; end
      default: ;
    endcase
  endtask

  // Monitor: on every busy 1->0 transition compare committed HI/LO and busy length.
  initial begin
    logic prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (prev_busy && busy !== 1'b1) begin
        if (!abort_flag) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit actual=hi %h lo %h required=no commit", hi, lo);
          end else begin
            e = sb.pop_front();
            chk("commit_hi", hi, e.h);
            chk("commit_lo", lo, e.l);
            chk("busy_len", 32'(bcnt), 32'(e.lat));
          end
        end
        bcnt = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  // Issue one mult/div op at a negedge and return at the first idle negedge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit chk_stall, input bit inject_mthi);
    exp_t e;
    int   n, sc;
    e_valid = 1'b1; e_op = op; rs_val = a; rt_val = b;
    #1;
    chk("start_on_issue", {31'd0, start}, 32'd1);
    if (chk_stall) chk("stall_on_start", {31'd0, stall_d}, 32'd1);
    ref_md(op, a, b, e.h, e.l);
    e.lat = (op <= 3'd2) ? ML : DL;
    sb.push_back(e);
    hi_m = e.h; lo_m = e.l;
    @(negedge clk);
    e_valid = 1'b0; e_op = 3'd0;
    if (inject_mthi) begin
      e_valid = 1'b1; e_op = 3'd5; rs_val = 32'h0000_1234;
      #1;
      chk("no_start_while_busy", {31'd0, start}, 32'd0);
    end
    n = 0; sc = 0;
    while (busy === 1'b1 && n < 40) begin
      if (stall_d === 1'b1) sc++;
      @(negedge clk);
      e_valid = 1'b0; e_op = 3'd0;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL busy_timeout actual=busy after %0d cycles required=idle", n);
    end
    if (chk_stall) begin
      chk("stall_busy_cycles", 32'(sc), 32'(e.lat));
      chk("stall_released", {31'd0, stall_d}, 32'd0);
    end
  endtask

  // mthi/mtlo in idle: written at the next edge, unit stays idle.
  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    e_valid = 1'b1; e_op = op; rs_val = a; rt_val = $urandom;
    #1;
    chk("mt_no_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    e_valid = 1'b0; e_op = 3'd0;
    if (op == 3'd5) begin
      hi_m = a;
      chk("mthi_write", hi, a);
    end else begin
      lo_m = a;
      chk("mtlo_write", lo, a);
    end
    chk("mt_busy_low", {31'd0, busy}, 32'd0);
  endtask

  // Start a div and bring the bench to the negedge of busy cycle 3.
  task automatic start_div_to_cycle3(input logic [31:0] a, input logic [31:0] b);
    e_valid = 1'b1; e_op = 3'd3; rs_val = a; rt_val = b;
    @(negedge clk);
    e_valid = 1'b0; e_op = 3'd0;
    repeat (2) @(negedge clk);
    chk("busy_cycle3", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; e_valid = 1'b0; e_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    d_md_use = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_start", {31'd0, start}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    do_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    do_op(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    d_md_use = 1'b1;
    do_op(3'd1, 32'd3, 32'd5, 1'b1, 1'b1);
    d_md_use = 1'b0;
    chk("mthi_ignored_hi", hi, 32'd0);
    chk("mult_small_lo", lo, 32'd15);

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    do_mt(3'd6, 32'h0000_ABCD);
    do_mt(3'd5, 32'h0000_0055);
    do_op(3'd4, 32'd9, 32'd0, 1'b0, 1'b0);
    chk("divu0_hi", hi, 32'h0000_0055);
    chk("divu0_lo", lo, 32'h0000_ABCD);
    do_op(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    chk("div0_lo", lo, 32'h0000_ABCD);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if (op >= 3'd5) do_mt(op, a);
      else do_op(op, a, b, 1'b0, 1'b0);
    end

    do_mt(3'd5, 32'h0000_DEAD);
    start_div_to_cycle3(32'd100, 32'd7);
    abort_flag = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_reset_busy", {31'd0, busy}, 32'd0);
    chk("abort_reset_hi", hi, 32'd0);
    chk("abort_reset_lo", lo, 32'd0);
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (12) @(negedge clk);
    chk("no_late_commit_hi", hi, 32'd0);
    chk("no_late_commit_lo", lo, 32'd0);
    abort_flag = 1'b0;

`ifdef MD_CANCEL_EN
    do_mt(3'd5, 32'h0000_1111);
    do_mt(3'd6, 32'h0000_2222);
    start_div_to_cycle3(32'd100, 32'd7);
    abort_flag = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h0000_1111);
    chk("cancel_lo", lo, 32'h0000_2222);
    repeat (12) @(negedge clk);
    chk("cancel_no_commit", hi, 32'h0000_1111);
    abort_flag = 1'b0;
    cancel = 1'b1; e_valid = 1'b1; e_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
    #1;
    chk("cancel_idle_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    e_op = 3'd5; rs_val = 32'h0000_9999;
    @(negedge clk);
    chk("cancel_idle_mthi", hi, 32'h0000_1111);
    cancel = 1'b0; e_valid = 1'b0; e_op = 3'd0;
    @(negedge clk);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
